// File: rtl/interval_timer_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// interval_timer_arbiter_pkg
// Shared definitions for the interval timer arbiter: default sizing constants
// and the controller state encoding.
// ---------------------------------------------------------------------------
package interval_timer_arbiter_pkg;

   localparam int DEFAULT_NUM_REQ = 4;
   localparam int DEFAULT_WIDTH   = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_ABORTED = 2'd3
   } state_t;

endpackage

// File: rtl/interval_timer_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts at index ptr,
// walks upward and wraps to 0; the first active request wins.
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - index that has highest priority this cycle
//   gnt    - one-hot grant (zero when nothing is requested)
//   gnt_id - binary index of the granted requester
//   any    - high when some request is granted
// ---------------------------------------------------------------------------
module rr_arbiter
   import interval_timer_arbiter_pkg::*;
#(
   parameter int N    = DEFAULT_NUM_REQ,
   parameter int ID_W = $clog2(DEFAULT_NUM_REQ)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            any
);

   // Two ordered passes: indices at or above ptr first, then the wrapped
   // indices below ptr. This avoids any modulo arithmetic on the index.
   always_comb begin
      // NOTE: every output gets a default before the search so no path
      // through this block leaves a value unassigned (no latch).
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (i >= int'(ptr))) begin
            any    = 1'b1;
            gnt[i] = 1'b1;
            gnt_id = ID_W'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (i < int'(ptr))) begin
            any    = 1'b1;
            gnt[i] = 1'b1;
            gnt_id = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/interval_timer_arbiter.sv
// ---------------------------------------------------------------------------
// interval_timer_arbiter
// Several requesters share one interval counter. In IDLE the round-robin
// winner is accepted, its length latched, and the counter runs for that many
// cycles; a one-cycle completion pulse then reports the winner's id.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - one request bit per requester
//   req_len     - packed interval lengths, requester i at [i*WIDTH +: WIDTH]
//   req_ready   - one-hot acceptance (IDLE only)
//   abort       - synchronous cancel of the active interval
//   busy        - high in every state except IDLE
//   count       - live counter value
//   done_valid  - one-cycle completion pulse
//   done_id     - id of the requester whose interval completed
// ---------------------------------------------------------------------------
module interval_timer_arbiter
   import interval_timer_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int WIDTH   = DEFAULT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_len,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       abort,
   output logic                       busy,
   output logic [WIDTH-1:0]           count,
   output logic                       done_valid,
   output logic [$clog2(NUM_REQ)-1:0] done_id
);

   localparam int              ID_W    = $clog2(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   state_t           r_state;
   logic [ID_W-1:0]  r_ptr;
   logic [ID_W-1:0]  r_id;
   logic [WIDTH-1:0] r_len;
   logic [WIDTH-1:0] r_count;

   logic [NUM_REQ-1:0] w_gnt;
   logic [ID_W-1:0]    w_gnt_id;
   logic               w_any;
   logic               w_accept;
   logic [WIDTH-1:0]   w_sel_len;
   logic [ID_W-1:0]    w_ptr_next;
   logic [WIDTH-1:0]   w_len_m1;
   logic               w_done_valid;

   rr_arbiter #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_rr_arbiter (
      .req    (req_valid),
      .ptr    (r_ptr),
      .gnt    (w_gnt),
      .gnt_id (w_gnt_id),
      .any    (w_any)
   );

   // Pick the winner's length with a one-hot mux instead of a variable slice.
   always_comb begin
      w_sel_len = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) w_sel_len = req_len[i*WIDTH +: WIDTH];
      end
   end

   // Acceptance depends only on state, reset and req_valid; abort never
   // reaches req_ready. Gating with rst_n keeps req_ready low during reset.
   assign w_accept   = (r_state == ST_IDLE) && rst_n && w_any;
   assign req_ready  = ((r_state == ST_IDLE) && rst_n) ? w_gnt : '0;
   assign w_ptr_next = (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;
   assign w_len_m1   = r_len - 1'b1;

   // An abort arriving in DONE cancels that cycle's completion pulse.
   assign w_done_valid = (r_state == ST_DONE) && !abort;
   assign done_valid   = w_done_valid;
   assign done_id      = w_done_valid ? r_id : '0;
   assign busy         = (r_state != ST_IDLE);
   assign count        = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_len   <= '0;
         r_count <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_id    <= w_gnt_id;
                  r_len   <= w_sel_len;
                  r_count <= '0;
                  r_ptr   <= w_ptr_next;
                  r_state <= (w_sel_len == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_state <= ST_ABORTED;
               end else if (r_count == w_len_m1) begin
                  // The last RUN cycle leaves count at len-1 for DONE.
                  r_state <= ST_DONE;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            ST_DONE: begin
               if (abort) begin
                  r_state <= ST_ABORTED;
               end else begin
                  r_state <= ST_IDLE;
                  r_count <= '0;
               end
            end
            ST_ABORTED: begin
               r_state <= ST_IDLE;
               r_count <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/interval_timer_arbiter.md
INTERVAL_TIMER_ARBITER -- requirements
Module: interval_timer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL give the number of requesters sharing the single interval counter (2..16).
REQ-002 Parameter WIDTH, default 8, SHALL give the counter and interval-length width in bits.
REQ-003 Port clk, input, 1 bit, SHALL be the clock; every state element SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port req_valid, input, NUM_REQ bits, SHALL carry one interval request per requester.
REQ-006 Port req_len, input, NUM_REQ*WIDTH bits, SHALL carry the requested interval length, with requester i in bits [i*WIDTH +: WIDTH].
REQ-007 Port req_ready, output, NUM_REQ bits, SHALL be one-hot or zero and indicates acceptance.
REQ-008 Port abort, input, 1 bit, SHALL be a synchronous cancel of the active interval.
REQ-009 Port busy, output, 1 bit, SHALL be high while any state other than IDLE is active.
REQ-010 Port count, output, WIDTH bits, SHALL be the live counter value.
REQ-011 Port done_valid, output, 1 bit, SHALL be a one-cycle completion pulse.
REQ-012 Port done_id, output, $clog2(NUM_REQ) bits, SHALL identify the requester whose interval completed.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, RUN, DONE, ABORTED.
REQ-014 In IDLE with any req_valid high, req_ready SHALL be asserted combinationally for the round-robin winner only, and the transfer occurs that cycle.
REQ-015 Round-robin: the search SHALL start at pointer ptr (reset 0); after a grant to i, ptr SHALL become (i+1) mod NUM_REQ; ptr SHALL NOT change without a grant.
REQ-016 On transfer, the block SHALL latch the winner id and req_len, clear count to 0, and enter RUN, or enter DONE directly if req_len == 0.
REQ-017 In RUN, count SHALL increment by 1 per cycle, modulo 2^WIDTH with no carry out; when count == len-1 the next state SHALL be DONE.
REQ-018 Timing: accept at cycle T, RUN for cycles T+1..T+len, done_valid=1 at T+len+1 with done_id equal to the latched id, IDLE at T+len+2.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE; count SHALL hold its final value in DONE and clear to 0 on entry to IDLE.
REQ-020 req_ready SHALL be 0 in RUN, DONE and ABORTED; requests held high SHALL remain pending with no loss.
REQ-021 When abort=1 in RUN or DONE, the next state SHALL be ABORTED and done_valid SHALL be suppressed in that cycle; ABORTED SHALL last one cycle and then return to IDLE.
REQ-022 abort SHALL be ignored in IDLE and ABORTED.
REQ-023 A req_valid deasserted before its grant SHALL be treated as withdrawn.
REQ-024 req_len SHALL be sampled only at transfer; later changes SHALL NOT affect the active interval.
REQ-025 len = 2^WIDTH-1 SHALL run the full range with count wrapping never observed.

Reset
REQ-026 While rst_n=0, the state SHALL be IDLE and ptr, count, latched id, latched len, done_valid and done_id SHALL all be 0; req_ready SHALL be 0 and busy SHALL be 0.
REQ-027 Reset asserted mid-RUN SHALL drop the interval with no done_valid pulse.
REQ-028 After rst_n deasserts, the first grant SHALL go to the lowest-index valid requester.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE, ABORTED) and the default NUM_REQ/WIDTH constants.
REQ-030 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: req, ptr; outputs: one-hot gnt, gnt_id, any).
REQ-031 The counter and FSM SHALL reside in interval_timer_arbiter itself; the design SHALL contain no latches and no combinational path from abort to req_ready.

Verification
REQ-032 Reset, then req_valid=4'b0001 with len0=5 -> req_ready[0] at T; count 0..4 over T+1..T+5; done_valid, done_id=0 at T+6.
REQ-033 All four requesters valid and held, each len=1 -> grant order 0,1,2,3,0; each done_valid pulse 3 cycles apart.
REQ-034 len=0 on requester 2 -> done_valid with done_id=2 at T+1; busy high for exactly 1 cycle.
REQ-035 Requester 1 with len=10, abort pulsed at T+4 -> ABORTED at T+5, no done_valid, IDLE at T+6, next grant possible at T+6.
REQ-036 rst_n pulsed low at T+3 of a len=8 interval -> all outputs 0 immediately; no done_valid; ptr=0 after release.
REQ-037 WIDTH=8, len=255 -> count reaches 254, done_valid at T+256, no wrap to 0 before DONE.
